// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants and helpers for the 3x4 matrix keypad scanner.
//   state_t   - scan FSM state encoding (legacy-compatible localparam constants)
//   COL_*     - active-low column strobe patterns
//   KEY_*     - codes for the '*' and '#' keys
//   row_valid - true when exactly one row line is low
//   key_encode- maps (column strobe, row pattern) to a 4-bit key code
//   col_next  - next column in the COL1 -> COL2 -> COL3 -> COL1 rotation
package keypad_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle     = 2'd0;
    localparam state_t StScan     = 2'd1;
    localparam state_t StDebounce = 2'd2;
    localparam state_t StPressed  = 2'd3;

    localparam logic [2:0] COL_NONE = 3'b111;
    localparam logic [2:0] COL1     = 3'b011;
    localparam logic [2:0] COL2     = 3'b101;
    localparam logic [2:0] COL3     = 3'b110;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    // Multi-key and ghosting patterns have more than one row low; reject them.
    function automatic logic row_valid(input logic [3:0] row);
        logic [3:0] low;
        low = ~row;
        return (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [3:0] key_encode(input logic [2:0] col, input logic [3:0] row);
        logic [3:0] col_idx;
        logic [3:0] code;
        case (col)
            COL2:    col_idx = 4'd1;
            COL3:    col_idx = 4'd2;
            default: col_idx = 4'd0;
        endcase
        case (row)
            4'b0111: code = 4'd1 + col_idx;
            4'b1011: code = 4'd4 + col_idx;
            4'b1101: code = 4'd7 + col_idx;
            default: begin
                // Bottom row: '*', '0', '#'
                case (col)
                    COL2:    code = 4'd0;
                    COL3:    code = KEY_HASH;
                    default: code = KEY_STAR;
                endcase
            end
        endcase
        return code;
    endfunction

    function automatic logic [2:0] col_next(input logic [2:0] col);
        logic [2:0] nxt;
        case (col)
            COL1:    nxt = COL2;
            COL2:    nxt = COL3;
            default: nxt = COL1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/keypad_ctrl_fifo.sv
// key_fifo: small synchronous FIFO for 4-bit key codes, first-word fall-through.
//   clk, rstn - clock, asynchronous active-low reset (contents cleared)
//   push_i    - write data_i; accepted when not full, or when full with a same-cycle pop
//   data_i    - code to enqueue
//   pop_i     - drop the head entry; ignored while empty
//   data_o    - current head entry (0 while empty)
//   full_o    - DEPTH entries held
//   empty_o   - no entries held
module key_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push_i,
    input  logic [3:0] data_i,
    input  logic       pop_i,
    output logic [3:0] data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PtrLast   = AW'(DEPTH - 1);
    localparam logic [AW:0]   CountFull = (AW + 1)'(DEPTH);

    logic [3:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CountFull);
    assign empty_o = (count_q == '0);
    assign data_o  = empty_o ? 4'd0 : mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a push while full still lands.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 4'd0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/keypad_ctrl.sv
// keypad_ctrl: scan controller for a 3-column x 4-row matrix keypad.
// Strobes one column at a time (active low) every SCAN_DIV clocks, synchronises the row
// lines, debounces press and release over DEBOUNCE ticks, and queues one code per press.
//   clk, rstn - clock, asynchronous active-low reset
//   scan_en   - 1 = scanning enabled; 0 returns to idle (queued codes kept)
//   key_row   - row lines, active low, asynchronous to clk
//   key_col   - registered column strobes, active-low one-hot, 111 = none
//   key_code  - FIFO head code, meaningful while key_valid
//   key_valid - FIFO not empty
//   key_ready - consumer takes the head when key_valid & key_ready
//   overflow  - one-cycle pulse when a confirmed code is dropped on a full FIFO
module keypad_ctrl #(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       scan_en,
    input  logic [3:0] key_row,
    output logic [2:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overflow
);

    import keypad_pkg::*;

    localparam int unsigned     DivW   = $clog2(SCAN_DIV);
    localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);
    localparam logic [3:0]      DebMax = 4'(DEBOUNCE);

    state_t          state_q, state_d;
    logic [2:0]      col_q, col_d;
    logic [DivW-1:0] div_q, div_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      rcnt_q, rcnt_d;
    logic [3:0]      pat_q, pat_d;
    logic [3:0]      rs_meta_q, rs_q;
    logic            overflow_q, overflow_d;

    logic            tick;
    logic            rs_valid;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [3:0]      push_code;
    logic [3:0]      head_code;
    logic [3:0]      cnt_inc;
    logic [3:0]      rcnt_inc;

    // Two-flop synchroniser; idles at "no key" so reset never looks like a press.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rs_meta_q <= 4'hF;
            rs_q      <= 4'hF;
        end else begin
            rs_meta_q <= key_row;
            rs_q      <= rs_meta_q;
        end
    end

    assign rs_valid = row_valid(rs_q);
    assign tick     = (state_q != StIdle) && (div_q == DivMax);

    // Prescaler sits at 0 while idle so the first dwell after enable is a full SCAN_DIV.
    always_comb begin
        if (!scan_en || (state_q == StIdle)) begin
            div_d = '0;
        end else if (tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    assign cnt_inc  = cnt_q + 4'd1;
    assign rcnt_inc = rcnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        pat_d   = pat_q;
        push    = 1'b0;

        if (!scan_en) begin
            state_d = StIdle;
            col_d   = COL_NONE;
            cnt_d   = '0;
            rcnt_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StScan;
                    col_d   = COL1;
                end
                StScan: begin
                    if (tick) begin
                        if (rs_valid) begin
                            pat_d = rs_q;
                            cnt_d = 4'd1;
                            if (DEBOUNCE == 1) begin
                                push    = 1'b1;
                                rcnt_d  = '0;
                                state_d = StPressed;
                            end else begin
                                state_d = StDebounce;
                            end
                        end else begin
                            col_d = col_next(col_q);
                        end
                    end
                end
                StDebounce: begin
                    if (tick) begin
                        if (rs_q == pat_q) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == DebMax) begin
                                push    = 1'b1;
                                rcnt_d  = '0;
                                state_d = StPressed;
                            end
                        end else begin
                            // Bounce: resume scanning from the next column.
                            cnt_d   = '0;
                            col_d   = col_next(col_q);
                            state_d = StScan;
                        end
                    end
                end
                StPressed: begin
                    if (tick) begin
                        if (rs_q == 4'hF) begin
                            rcnt_d = rcnt_inc;
                            if (rcnt_inc == DebMax) begin
                                rcnt_d  = '0;
                                cnt_d   = '0;
                                col_d   = col_next(col_q);
                                state_d = StScan;
                            end
                        end else begin
                            rcnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    col_d   = COL_NONE;
                end
            endcase
        end
    end

    // rs_q equals the latched pattern whenever push is raised.
    assign push_code  = key_encode(col_q, rs_q);
    assign pop        = ~fifo_empty & key_ready;
    assign overflow_d = push & fifo_full & ~pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            col_q      <= COL_NONE;
            div_q      <= '0;
            cnt_q      <= '0;
            rcnt_q     <= '0;
            pat_q      <= 4'hF;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            rcnt_q     <= rcnt_d;
            pat_q      <= pat_d;
            overflow_q <= overflow_d;
        end
    end

    key_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .data_i  (push_code),
        .pop_i   (pop),
        .data_o  (head_code),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign key_col   = col_q;
    assign key_code  = head_code;
    assign key_valid = ~fifo_empty;
    assign overflow  = overflow_q;

endmodule
